// File: rtl/cpu_port_responder_pkg.sv
// Shared CPU-bus definitions: C1 command codes, bus widths, cache geometry,
// the responder state type and small command-decode helpers.
package cpu_port_responder_pkg;

    localparam int CACHE_TAG_SIZE    = 10;
    localparam int CACHE_SET_SIZE    = 5;
    localparam int CACHE_OFFSET_SIZE = 4;
    localparam int ADDR1_BUS_SIZE    = 15;
    localparam int DATA_BUS_SIZE     = 16;
    localparam int CTR1_BUS_SIZE     = 3;
    localparam int BE_ADDR_SIZE      = CACHE_TAG_SIZE + CACHE_SET_SIZE + CACHE_OFFSET_SIZE;
    localparam int BE_DATA_SIZE      = 32;

    // Response shares its code with WRITE32; the two travel in opposite directions.
    localparam logic [CTR1_BUS_SIZE-1:0] C1_NOP             = 3'd0;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_READ8           = 3'd1;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_READ16          = 3'd2;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_READ32          = 3'd3;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_INVALIDATE_LINE = 3'd4;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE8          = 3'd5;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE16         = 3'd6;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE32         = 3'd7;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_RESPONSE        = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR2   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RESP1   = 3'd3,
        ST_RESP2   = 3'd4,
        ST_RELEASE = 3'd5
    } cpu_port_state_t;

    function automatic logic is_cmd_f(input logic [CTR1_BUS_SIZE-1:0] cmd);
        case (cmd)
            C1_READ8, C1_READ16, C1_READ32, C1_INVALIDATE_LINE,
            C1_WRITE8, C1_WRITE16, C1_WRITE32: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    function automatic logic is_read_f(input logic [CTR1_BUS_SIZE-1:0] cmd);
        case (cmd)
            C1_READ8, C1_READ16, C1_READ32: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic [BE_DATA_SIZE-1:0] be_wdata_f(
        input logic [CTR1_BUS_SIZE-1:0] cmd,
        input logic [DATA_BUS_SIZE-1:0] hi16,
        input logic [DATA_BUS_SIZE-1:0] lo16
    );
        case (cmd)
            C1_WRITE8:  return {24'h000000, lo16[7:0]};
            C1_WRITE16: return {16'h0000, lo16};
            C1_WRITE32: return {hi16, lo16};
            default:    return 32'h00000000;
        endcase
    endfunction

endpackage

// File: rtl/cpu_port_responder_bus.sv
// Negedge-registered tristate driver for the shared C1/D1 lines; reset
// releases both buses immediately.
module cpu_port_responder_bus
    import cpu_port_responder_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_c1_en,
    input  logic [CTR1_BUS_SIZE-1:0] i_c1,
    input  logic                     i_d1_en,
    input  logic [DATA_BUS_SIZE-1:0] i_d1,
    inout  wire  [CTR1_BUS_SIZE-1:0] io_c1,
    inout  wire  [DATA_BUS_SIZE-1:0] io_d1
);

    logic                     r_c1_en;
    logic [CTR1_BUS_SIZE-1:0] r_c1;
    logic                     r_d1_en;
    logic [DATA_BUS_SIZE-1:0] r_d1;

    // Capture drive values half a cycle early so they are settled at the next posedge.
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_c1_en <= 1'b0;
            r_c1    <= C1_NOP;
            r_d1_en <= 1'b0;
            r_d1    <= 16'h0000;
        end else begin
            r_c1_en <= i_c1_en;
            r_c1    <= i_c1;
            r_d1_en <= i_d1_en;
            r_d1    <= i_d1;
        end
    end

    assign io_c1 = r_c1_en ? r_c1 : {CTR1_BUS_SIZE{1'bz}};
    assign io_d1 = r_d1_en ? r_d1 : {DATA_BUS_SIZE{1'bz}};

endmodule

// File: rtl/cpu_port_responder.sv
// Cache-side CPU bus responder: collects a two-cycle command, issues one
// backend request, then answers on C1/D1 and hands the bus back.
module cpu_port_responder
    import cpu_port_responder_pkg::*;
(
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [ADDR1_BUS_SIZE-1:0] A1,
    inout  wire  [DATA_BUS_SIZE-1:0]  D1,
    inout  wire  [CTR1_BUS_SIZE-1:0]  C1,
    output logic                      BE_REQ,
    output logic [CTR1_BUS_SIZE-1:0]  BE_CMD,
    output logic [BE_ADDR_SIZE-1:0]   BE_ADDR,
    output logic [BE_DATA_SIZE-1:0]   BE_WDATA,
    input  logic                      BE_ACK,
    input  logic [BE_DATA_SIZE-1:0]   BE_RDATA
);

    cpu_port_state_t             r_state;
    logic [CTR1_BUS_SIZE-1:0]    r_cmd;
    logic [ADDR1_BUS_SIZE-1:0]   r_addr_hi;
    logic [DATA_BUS_SIZE-1:0]    r_lo16;
    logic [BE_DATA_SIZE-1:0]     r_rdata;

    logic                        w_c1_en;
    logic [CTR1_BUS_SIZE-1:0]    w_c1;
    logic                        w_d1_en;
    logic [DATA_BUS_SIZE-1:0]    w_d1;

    // Transaction sequencer; the backend request fields are built in ADDR2 and held until ACK.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state   <= ST_IDLE;
            r_cmd     <= C1_NOP;
            r_addr_hi <= 15'h0000;
            r_lo16    <= 16'h0000;
            r_rdata   <= 32'h00000000;
            BE_REQ    <= 1'b0;
            BE_CMD    <= C1_NOP;
            BE_ADDR   <= 19'h00000;
            BE_WDATA  <= 32'h00000000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (is_cmd_f(C1)) begin
                        r_cmd     <= C1;
                        r_addr_hi <= A1;
                        r_lo16    <= D1;
                        r_state   <= ST_ADDR2;
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end
                ST_ADDR2: begin
                    BE_CMD   <= r_cmd;
                    BE_ADDR  <= {r_addr_hi, A1[CACHE_OFFSET_SIZE-1:0]};
                    BE_WDATA <= be_wdata_f(r_cmd, D1, r_lo16);
                    BE_REQ   <= 1'b1;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (BE_ACK) begin
                        BE_REQ  <= 1'b0;
                        r_rdata <= (r_cmd == C1_READ8) ? {24'h000000, BE_RDATA[7:0]} : BE_RDATA;
                        r_state <= ST_RESP1;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_RESP1: begin
                    r_state <= (r_cmd == C1_READ32) ? ST_RESP2 : ST_RELEASE;
                end
                ST_RESP2: begin
                    r_state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    BE_REQ  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus drive request per state; IDLE and ADDR2 keep both lines released.
    always_comb begin
        w_c1_en = 1'b0;
        w_c1    = C1_NOP;
        w_d1_en = 1'b0;
        w_d1    = 16'h0000;
        case (r_state)
            ST_WAIT: begin
                w_c1_en = 1'b1;
                w_c1    = C1_NOP;
            end
            ST_RESP1: begin
                w_c1_en = 1'b1;
                w_c1    = C1_RESPONSE;
                w_d1_en = is_read_f(r_cmd);
                w_d1    = r_rdata[15:0];
            end
            ST_RESP2: begin
                w_c1_en = 1'b1;
                w_c1    = C1_RESPONSE;
                w_d1_en = 1'b1;
                w_d1    = r_rdata[31:16];
            end
            ST_RELEASE: begin
                w_c1_en = 1'b1;
                w_c1    = C1_NOP;
            end
            default: begin
                w_c1_en = 1'b0;
                w_c1    = C1_NOP;
            end
        endcase
    end

    cpu_port_responder_bus u_bus (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .i_c1_en (w_c1_en),
        .i_c1    (w_c1),
        .i_d1_en (w_d1_en),
        .i_d1    (w_d1),
        .io_c1   (C1),
        .io_d1   (D1)
    );

endmodule

// File: tb/tb_cpu_port_responder.sv
// Scoreboard bench for cpu_port_responder: a CPU stimulus process, a backend
// model and a bus monitor, with expectations derived from byte-level rules.
module tb_cpu_port_responder;
    import cpu_port_responder_pkg::*;

    logic        CLK;
    logic        RESET;
    logic [14:0] A1;
    wire  [15:0] D1;
    wire  [2:0]  C1;
    logic        BE_REQ;
    logic [2:0]  BE_CMD;
    logic [18:0] BE_ADDR;
    logic [31:0] BE_WDATA;
    logic        BE_ACK;
    logic [31:0] BE_RDATA;

    logic [15:0] tb_d1;
    logic        tb_d1_en;
    logic [2:0]  tb_c1;
    logic        tb_c1_en;
    assign D1 = tb_d1_en ? tb_d1 : 16'bz;
    assign C1 = tb_c1_en ? tb_c1 : 3'bz;

    cpu_port_responder dut (
        .CLK(CLK), .RESET(RESET), .A1(A1), .D1(D1), .C1(C1),
        .BE_REQ(BE_REQ), .BE_CMD(BE_CMD), .BE_ADDR(BE_ADDR), .BE_WDATA(BE_WDATA),
        .BE_ACK(BE_ACK), .BE_RDATA(BE_RDATA)
    );

    typedef struct {
        logic [2:0]  cmd;
        logic [18:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
    } be_t;

    typedef struct {
        logic        has_data;
        logic [15:0] data;
        logic        first;
        logic        last;
    } beat_t;

    be_t   be_q[$];
    beat_t beat_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cmd_cyc = 0;
    int ack_cyc = 0;
    int done_cnt = 0;
    int target = 0;
    int rel_stage = 0;
    bit spur = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] c);
        if (c == C1_READ8 || c == C1_WRITE8) return 1;
        if (c == C1_READ16 || c == C1_WRITE16) return 2;
        if (c == C1_READ32 || c == C1_WRITE32) return 4;
        return 0;
    endfunction

    function automatic bit is_rd(input logic [2:0] c);
        return (c == C1_READ8 || c == C1_READ16 || c == C1_READ32);
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
        logic [31:0] t;
        t = w >> (8 * i);
        return t[7:0];
    endfunction

    // Backend model: checks request fields and latency, acks after the chosen delay.
    initial begin
        be_t cur;
        bit  busy;
        int  wait_cnt;
        busy = 1'b0;
        wait_cnt = 0;
        BE_ACK = 1'b0;
        BE_RDATA = 32'h0;
        forever begin
            @(negedge CLK);
            BE_ACK = 1'b0;
            if (!RESET) begin
                busy = 1'b0;
            end else if (busy) begin
                chk("be_hold_addr", {13'h0, BE_ADDR}, {13'h0, cur.addr});
                if (wait_cnt <= 1) begin
                    BE_ACK = 1'b1;
                    BE_RDATA = cur.rdata;
                    ack_cyc = cyc;
                    busy = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end else if (BE_REQ) begin
                if (be_q.size() == 0) begin
                    chk("be_unexpected_req", 32'h1, 32'h0);
                end else begin
                    cur = be_q.pop_front();
                    chk("be_req_latency", cyc, cmd_cyc + 2);
                    chk("be_cmd", {29'h0, BE_CMD}, {29'h0, cur.cmd});
                    chk("be_addr", {13'h0, BE_ADDR}, {13'h0, cur.addr});
                    chk("be_wdata", BE_WDATA, cur.wdata);
                    if (cur.delay == 0) begin
                        BE_ACK = 1'b1;
                        BE_RDATA = cur.rdata;
                        ack_cyc = cyc;
                    end else begin
                        busy = 1'b1;
                        wait_cnt = cur.delay;
                    end
                end
            end else if (spur) begin
                BE_ACK = 1'b1;
                BE_RDATA = $urandom;
            end
        end
    end

    // Bus monitor: pops an expected beat for every RESPONSE, then checks the release.
    always @(posedge CLK) begin
        if (RESET) begin
            if (rel_stage == 1) begin
                chk("rel_c1_en", {31'h0, dut.u_bus.r_c1_en}, 32'h1);
                chk("rel_c1_nop", {29'h0, C1}, {29'h0, C1_NOP});
                chk("rel_d1_en", {31'h0, dut.u_bus.r_d1_en}, 32'h0);
                rel_stage = 2;
            end else if (rel_stage == 2) begin
                chk("free_c1_en", {31'h0, dut.u_bus.r_c1_en}, 32'h0);
                chk("free_d1_en", {31'h0, dut.u_bus.r_d1_en}, 32'h0);
                rel_stage = 0;
                done_cnt++;
            end else if (dut.u_bus.r_c1_en) begin
                if (C1 == C1_RESPONSE) begin
                    if (beat_q.size() == 0) begin
                        chk("resp_unexpected", 32'h1, 32'h0);
                    end else begin
                        beat_t b;
                        b = beat_q.pop_front();
                        if (b.first) chk("resp_latency", cyc, ack_cyc + 1);
                        chk("resp_d1_en", {31'h0, dut.u_bus.r_d1_en}, {31'h0, b.has_data});
                        if (b.has_data) chk("resp_d1", {16'h0, D1}, {16'h0, b.data});
                        if (b.last) rel_stage = 1;
                    end
                end else begin
                    chk("wait_c1_nop", {29'h0, C1}, {29'h0, C1_NOP});
                    chk("wait_d1_en", {31'h0, dut.u_bus.r_d1_en}, 32'h0);
                end
            end
        end
    end

    task automatic issue(input logic [2:0] cmd, input logic [14:0] ahi, input logic [3:0] off,
                         input logic [15:0] lo, input logic [15:0] hi, input int delay,
                         input logic [31:0] rdata, input bit want_resp);
        be_t e;
        int n;
        logic [31:0] cpu;
        n = size_of(cmd);
        cpu = {hi, lo};
        e.cmd = cmd;
        e.addr = {ahi, off};
        e.wdata = 32'h0;
        if (!is_rd(cmd))
            for (int i = 0; i < n; i++) e.wdata = e.wdata | ({24'h0, byte_of(cpu, i)} << (8 * i));
        e.delay = delay;
        e.rdata = rdata;
        be_q.push_back(e);
        if (want_resp) begin
            int nb;
            nb = is_rd(cmd) ? (n + 1) / 2 : 1;
            for (int k = 0; k < nb; k++) begin
                beat_t b;
                b.has_data = is_rd(cmd);
                b.data = 16'h0;
                for (int j = 0; j < 2; j++)
                    if (b.has_data && (2 * k + j) < n)
                        b.data = b.data | ({8'h0, byte_of(rdata, 2 * k + j)} << (8 * j));
                b.first = (k == 0);
                b.last = (k == nb - 1);
                beat_q.push_back(b);
            end
            target++;
        end
        @(negedge CLK);
        tb_c1 = cmd; tb_c1_en = 1'b1; A1 = ahi; tb_d1 = lo; tb_d1_en = 1'b1;
        @(posedge CLK);
        cmd_cyc = cyc;
        @(negedge CLK);
        tb_c1 = C1_NOP; A1 = {11'h0, off}; tb_d1 = hi;
        @(posedge CLK);
        chk("addr2_no_drive", {30'h0, dut.u_bus.r_c1_en, dut.u_bus.r_d1_en}, 32'h0);
        @(negedge CLK);
        tb_c1_en = 1'b0; tb_d1_en = 1'b0;
    endtask

    task automatic txn(input logic [2:0] cmd, input logic [14:0] ahi, input logic [3:0] off,
                       input logic [15:0] lo, input logic [15:0] hi, input int delay,
                       input logic [31:0] rdata);
        issue(cmd, ahi, off, lo, hi, delay, rdata, 1'b1);
        for (int i = 0; i < 200 && done_cnt < target; i++) @(posedge CLK);
        chk("txn_done", done_cnt, target);
    endtask

    initial begin
        RESET = 1'b0; A1 = 15'h0; tb_d1 = 16'h0; tb_d1_en = 1'b0; tb_c1 = C1_NOP; tb_c1_en = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_be_req", {31'h0, BE_REQ}, 32'h0);
        chk("rst_be_cmd_addr", {10'h0, BE_CMD, BE_ADDR}, 32'h0);
        chk("rst_be_wdata", BE_WDATA, 32'h0);
        chk("rst_bus_en", {30'h0, dut.u_bus.r_c1_en, dut.u_bus.r_d1_en}, 32'h0);
        @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(posedge CLK);

        txn(C1_READ32, 15'h22, 4'h3, 16'h1111, 16'h2222, 0, 32'hDDCCBBAA);
        txn(C1_WRITE32, 15'h22, 4'h3, 16'h7CC8, 16'h0525, 0, 32'h0);
        txn(C1_READ8, 15'h1234, 4'hA, 16'h0, 16'h0, 5, 32'h000000FF);
        txn(C1_INVALIDATE_LINE, 15'h22, 4'h3, 16'h0, 16'h0, 2, 32'h0);

        // Reset while the backend is still busy: the transaction vanishes.
        issue(C1_READ16, 15'h0155, 4'h7, 16'h0, 16'h0, 30, 32'hCAFEF00D, 1'b0);
        for (int i = 0; i < 20 && !BE_REQ; i++) @(posedge CLK);
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        chk("midrst_bus_en", {30'h0, dut.u_bus.r_c1_en, dut.u_bus.r_d1_en}, 32'h0);
        chk("midrst_be_req", {31'h0, BE_REQ}, 32'h0);
        chk("midrst_be_addr", {13'h0, BE_ADDR}, 32'h0);
        @(negedge CLK);
        RESET = 1'b1;
        repeat (35) @(posedge CLK);
        txn(C1_READ16, 15'h7FFF, 4'hF, 16'h0, 16'h0, 1, 32'h89ABCDEF);

        // Idle bus with NOP then Z on C1 and spurious acks.
        @(negedge CLK);
        tb_c1 = C1_NOP; tb_c1_en = 1'b1; spur = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                @(negedge CLK);
                tb_c1_en = 1'b0;
            end
            @(posedge CLK);
            chk("idle_be_req", {31'h0, BE_REQ}, 32'h0);
            chk("idle_bus_en", {30'h0, dut.u_bus.r_c1_en, dut.u_bus.r_d1_en}, 32'h0);
        end
        @(negedge CLK);
        spur = 1'b0; tb_c1_en = 1'b0;
        @(posedge CLK);

        for (int t = 0; t < 40; t++) begin
            logic [2:0] c;
            c = 3'($urandom_range(1, 7));
            txn(c, 15'($urandom), 4'($urandom), 16'($urandom), 16'($urandom),
                $urandom_range(0, 6), $urandom);
        end

        repeat (3) @(posedge CLK);
        chk("be_q_empty", be_q.size(), 32'h0);
        chk("beat_q_empty", beat_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
